// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage of the 5-stage MIPS pipeline.
// Resolves branches, runs load/store accesses over a req/ack data-memory
// handshake, stalls upstream while an access is outstanding, holds the
// MEM/WB pipeline register and aborts hung accesses with a timeout counter.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses
// (misalign_err pulse, no issue). Without it the low address bits are
// cleared and misalign_err is tied low.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic [31:0] branch_target,
  input  logic        Zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data2,
  input  logic [4:0]  write_reg,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWrite_wb,
  output logic        MemToReg_wb,
  output logic [31:0] mem_data_wb,
  output logic [31:0] alu_result_wb,
  output logic [4:0]  write_reg_wb,
  output logic        timeout_err,
  output logic        misalign_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0] cnt;
  logic          mem_op;
  logic          misaligned;
  logic          issue;
  logic          expire;
  logic          complete;
  logic [31:0]   issue_addr;

  logic          hold_regwrite;
  logic          hold_memtoreg;
  logic [4:0]    hold_write_reg;
  logic [31:0]   hold_alu;

  assign mem_op    = MemRead | MemWrite;
  assign pc_target = branch_target;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mem_op & (alu_result[1:0] != 2'b00);
  assign issue_addr = alu_result;
`else
  assign misaligned = 1'b0;
  assign issue_addr = {alu_result[31:2], 2'b00};
`endif

  // State register for the IDLE/WAIT access sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall/branch outputs and access completion/abort decode.
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    pc_src     = 1'b0;
    issue      = 1'b0;
    expire     = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: begin
        issue     = mem_op & ~misaligned;
        stall_out = issue;
        pc_src    = Branch & Zero;
        if (issue) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        complete  = dmem_ack;
        expire    = (cnt == CNT_LAST) & ~dmem_ack;
        stall_out = ~dmem_ack & ~expire;
        if (complete || expire) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request registers, hold registers, timeout counter and MEM/WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      cnt            <= '0;
      hold_regwrite  <= 1'b0;
      hold_memtoreg  <= 1'b0;
      hold_write_reg <= '0;
      hold_alu       <= '0;
      RegWrite_wb    <= 1'b0;
      MemToReg_wb    <= 1'b0;
      mem_data_wb    <= '0;
      alu_result_wb  <= '0;
      write_reg_wb   <= '0;
      timeout_err    <= 1'b0;
    end else begin
      timeout_err <= expire;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            dmem_req       <= 1'b1;
            dmem_we        <= MemWrite;
            dmem_addr      <= issue_addr;
            dmem_wdata     <= read_data2;
            cnt            <= '0;
            hold_regwrite  <= RegWrite;
            hold_memtoreg  <= MemToReg;
            hold_write_reg <= write_reg;
            hold_alu       <= alu_result;
            RegWrite_wb    <= 1'b0;
            MemToReg_wb    <= 1'b0;
          end else if (misaligned) begin
            RegWrite_wb <= 1'b0;
            MemToReg_wb <= 1'b0;
          end else begin
            RegWrite_wb   <= RegWrite;
            MemToReg_wb   <= MemToReg;
            alu_result_wb <= alu_result;
            write_reg_wb  <= write_reg;
          end
        end
        ST_WAIT: begin
          if (complete) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            mem_data_wb   <= dmem_rdata;
            RegWrite_wb   <= hold_regwrite;
            MemToReg_wb   <= hold_memtoreg;
            write_reg_wb  <= hold_write_reg;
            alu_result_wb <= hold_alu;
          end else if (expire) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            RegWrite_wb <= 1'b0;
            MemToReg_wb <= 1'b0;
          end else begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CW'(1);
            end
            RegWrite_wb <= 1'b0;
            MemToReg_wb <= 1'b0;
          end
        end
        default: begin
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle trap pulse for a misaligned access presented while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= (state == ST_IDLE) & misaligned;
    end
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: self-checking bench for mem_stage_ctrl.
// Table-driven pass-through/branch vectors, hand sequences for the
// multi-cycle cases, then randomized instructions checked against a
// transaction-level model (stall count and write-back per instruction).
module tb_mem_stage_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemToReg, RegWrite, MemRead, MemWrite, Branch, Zero;
  logic [31:0] branch_target, alu_result, read_data2, dmem_rdata;
  logic [4:0]  write_reg;
  logic        dmem_ack;
  logic        pc_src, stall_out, dmem_req, dmem_we;
  logic [31:0] pc_target, dmem_addr, dmem_wdata;
  logic        RegWrite_wb, MemToReg_wb, timeout_err, misalign_err;
  logic [31:0] mem_data_wb, alu_result_wb;
  logic [4:0]  write_reg_wb;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        mem_to_reg, reg_write, mem_read, mem_write, branch, zero;
    logic [31:0] target, alu, wdata;
    logic [4:0]  wreg;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic        exp_pc_src;
    logic        exp_rw;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_alu;
  } vec_t;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .branch_target(branch_target),
    .Zero(Zero), .alu_result(alu_result), .read_data2(read_data2),
    .write_reg(write_reg), .pc_src(pc_src), .pc_target(pc_target),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .RegWrite_wb(RegWrite_wb), .MemToReg_wb(MemToReg_wb),
    .mem_data_wb(mem_data_wb), .alu_result_wb(alu_result_wb),
    .write_reg_wb(write_reg_wb), .timeout_err(timeout_err),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input instr_t in);
    MemToReg      = in.mem_to_reg;
    RegWrite      = in.reg_write;
    MemRead       = in.mem_read;
    MemWrite      = in.mem_write;
    Branch        = in.branch;
    Zero          = in.zero;
    branch_target = in.target;
    alu_result    = in.alu;
    read_data2    = in.wdata;
    write_reg     = in.wreg;
  endtask

  function automatic logic [31:0] addr_model(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic instr_t mk(input int kind, input logic [31:0] alu,
                                input logic [31:0] wd, input logic [4:0] wr,
                                input logic z, input logic [31:0] tgt);
    instr_t i;
    i.mem_to_reg = (kind == 1);
    i.reg_write  = (kind == 0) || (kind == 1);
    i.mem_read   = (kind == 1);
    i.mem_write  = (kind == 2);
    i.branch     = (kind == 3);
    i.zero       = z;
    i.target     = tgt;
    i.alu        = alu;
    i.wdata      = wd;
    i.wreg       = wr;
    return i;
  endfunction

  // Present one instruction, hold it while stalled, act as the memory
  // (ack in WAIT cycle 'lat'), and report stall and request cycle counts.
  task automatic run_instr(input instr_t in, input int lat, input logic [31:0] rd,
                           output int stalls, output int reqc);
    bit done = 0;
    stalls = 0;
    reqc   = 0;
    apply_stimulus(in);
    for (int c = 0; c < 64 && !done; c++) begin
      dmem_ack   = dmem_req && (reqc == lat);
      dmem_rdata = dmem_ack ? rd : $urandom;
      #1;
      if (c == 0) check_output("pc_src_idle", pc_src, in.branch & in.zero);
      if (dmem_req) begin
        check_output("wait_bubble", RegWrite_wb, 0);
        check_output("wait_pc_src", pc_src, 0);
        check_output("req_addr", dmem_addr, addr_model(in.alu));
        check_output("req_we", dmem_we, in.mem_write);
        check_output("req_wdata", dmem_wdata, in.wdata);
        reqc++;
      end
      if (stall_out) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
    end
    dmem_ack = 1'b0;
    check_output("stall_bound", done, 1);
  endtask

  vec_t   vecs[5];
  instr_t nop;
  instr_t ins;
  int     st, rq;

  initial begin
    logic [31:0] last_md;
    logic [31:0] r;

    nop = mk(4, 0, 0, 0, 0, 0);
    apply_stimulus(nop);
    dmem_ack = 0;
    dmem_rdata = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_req", dmem_req, 0);
    check_output("rst_we", dmem_we, 0);
    check_output("rst_addr", dmem_addr, 0);
    check_output("rst_wdata", dmem_wdata, 0);
    check_output("rst_rw_wb", RegWrite_wb, 0);
    check_output("rst_mem_data_wb", mem_data_wb, 0);
    check_output("rst_alu_wb", alu_result_wb, 0);
    check_output("rst_terr", timeout_err, 0);
    check_output("rst_merr", misalign_err, 0);
    reset = 0;

    // Pass-through and branch table.
    vecs[0] = '{mk(0, 32'h1234, 0, 5, 0, 0), 0, 1, 5, 32'h1234};
    vecs[1] = '{mk(3, 32'h7, 0, 0, 1, 32'h100), 1, 0, 0, 32'h7};
    vecs[2] = '{mk(3, 32'h9, 0, 0, 0, 32'h200), 0, 0, 0, 32'h9};
    vecs[3] = '{mk(0, 32'hFFFF_FFFF, 0, 31, 1, 32'h44), 0, 1, 31, 32'hFFFF_FFFF};
    vecs[4] = '{mk(4, 32'h0, 0, 0, 0, 0), 0, 0, 0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].in);
      #1;
      check_output($sformatf("vec%0d_pc_src", i), pc_src, vecs[i].exp_pc_src);
      check_output($sformatf("vec%0d_pc_target", i), pc_target, vecs[i].in.target);
      check_output($sformatf("vec%0d_stall", i), stall_out, 0);
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_rw_wb", i), RegWrite_wb, vecs[i].exp_rw);
      check_output($sformatf("vec%0d_wreg_wb", i), write_reg_wb, vecs[i].exp_wreg);
      check_output($sformatf("vec%0d_alu_wb", i), alu_result_wb, vecs[i].exp_alu);
    end

    // Load, ack three cycles after req.
    run_instr(mk(1, 32'h40, 0, 9, 0, 0), 2, 32'hDEADBEEF, st, rq);
    check_output("load_stalls", st, 3);
    check_output("load_req_cycles", rq, 3);
    check_output("load_req_fall", dmem_req, 0);
    check_output("load_mem_data", mem_data_wb, 32'hDEADBEEF);
    check_output("load_memtoreg", MemToReg_wb, 1);
    check_output("load_rw", RegWrite_wb, 1);
    check_output("load_wreg", write_reg_wb, 9);
    check_output("load_alu", alu_result_wb, 32'h40);

    // Store with immediate ack.
    run_instr(mk(2, 32'h80, 32'hA5A5A5A5, 3, 0, 0), 0, 32'h0, st, rq);
    check_output("store_stalls", st, 1);
    check_output("store_req_cycles", rq, 1);
    check_output("store_rw", RegWrite_wb, 0);

    // Timeout: no ack ever.
    run_instr(mk(1, 32'h20, 0, 4, 0, 0), 1000, 32'h0, st, rq);
    check_output("to_stalls", st, T);
    check_output("to_req_cycles", rq, T);
    check_output("to_err", timeout_err, 1);
    check_output("to_rw", RegWrite_wb, 0);
    check_output("to_req_fall", dmem_req, 0);
    apply_stimulus(nop);
    dmem_ack = 1;
    #1;
    check_output("idle_ack_stall", stall_out, 0);
    @(posedge clk);
    #1;
    dmem_ack = 0;
    check_output("to_err_pulse", timeout_err, 0);
    check_output("idle_ack_req", dmem_req, 0);

    // Misaligned load at 0x42.
    run_instr(mk(1, 32'h42, 0, 6, 0, 0), 0, 32'h5555, st, rq);
`ifdef MISALIGN_TRAP_EN
    check_output("mis_stalls", st, 0);
    check_output("mis_req_cycles", rq, 0);
    check_output("mis_err", misalign_err, 1);
    check_output("mis_rw", RegWrite_wb, 0);
`else
    check_output("mis_stalls", st, 1);
    check_output("mis_req_cycles", rq, 1);
    check_output("mis_err", misalign_err, 0);
    check_output("mis_data", mem_data_wb, 32'h5555);
`endif

    // Reset asserted while in WAIT.
    apply_stimulus(mk(1, 32'h60, 0, 7, 0, 0));
    @(posedge clk);
    #1;
    check_output("rw_in_wait", dmem_req, 1);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    check_output("rstw_req", dmem_req, 0);
    check_output("rstw_rw", RegWrite_wb, 0);
    check_output("rstw_m2r", MemToReg_wb, 0);
    check_output("rstw_md", mem_data_wb, 0);
    check_output("rstw_alu", alu_result_wb, 0);
    check_output("rstw_wreg", write_reg_wb, 0);
    apply_stimulus(nop);
    #1;
    check_output("rstw_idle", stall_out, 0);
    @(posedge clk);
    #1;

    // Randomized instructions against a transaction-level model.
    last_md = 0;
    for (int n = 0; n < 60; n++) begin
      int kind, lat, exp_st;
      logic mis, exp_to;
      logic [31:0] rd;
      kind = $urandom_range(0, 3);
      lat  = $urandom_range(0, 5);
      r    = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      rd   = $urandom;
      ins  = mk(kind, r, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), $urandom);
`ifdef MISALIGN_TRAP_EN
      mis = (kind == 1 || kind == 2) && (r[1:0] != 2'b00);
`else
      mis = 0;
`endif
      exp_to = 0;
      if (mis) exp_st = 0;
      else if (kind == 1 || kind == 2) begin
        if (lat < T) exp_st = lat + 1;
        else begin
          exp_st = T;
          exp_to = 1;
        end
      end else exp_st = 0;
      run_instr(ins, lat, rd, st, rq);
      check_output($sformatf("rnd%0d_stalls", n), st, exp_st);
      check_output($sformatf("rnd%0d_terr", n), timeout_err, exp_to);
      check_output($sformatf("rnd%0d_merr", n), misalign_err, mis);
      if (mis || exp_to) begin
        check_output($sformatf("rnd%0d_bubble", n), RegWrite_wb, 0);
      end else begin
        if (kind == 1 || kind == 2) last_md = rd;
        check_output($sformatf("rnd%0d_rw", n), RegWrite_wb, ins.reg_write);
        check_output($sformatf("rnd%0d_m2r", n), MemToReg_wb, ins.mem_to_reg);
        check_output($sformatf("rnd%0d_wreg", n), write_reg_wb, ins.wreg);
        check_output($sformatf("rnd%0d_alu", n), alu_result_wb, ins.alu);
        check_output($sformatf("rnd%0d_md", n), mem_data_wb, last_md);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory stage of the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and feeding the write-back mux. It resolves branches (PCSrc) and performs load/store accesses over a req/ack data-memory handshake that may take several cycles. While an access is outstanding it stalls upstream, and it contains the MEM/WB pipeline register. A timeout counter aborts hung accesses.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles without ack before the access is aborted; legal range is ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemToReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  control from EX/MEM.
- branch_target  in  32  branch target from EX/MEM.
- Zero  in  1  ALU zero flag.
- alu_result  in  32  ALU result / memory address.
- read_data2  in  32  store data.
- write_reg  in  5  destination register.
- pc_src  out  1  combinational; take branch.
- pc_target  out  32  combinational; equals branch_target.
- stall_out  out  1  combinational; upstream (PC, IF/ID, ID/EX, EX/MEM) must hold while this is 1.
- dmem_req, dmem_we  out  1 each  registered request and write enable.
- dmem_addr, dmem_wdata  out  32 each  registered address and write data.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  access complete.
- RegWrite_wb, MemToReg_wb  out  1 each  MEM/WB control.
- mem_data_wb, alu_result_wb  out  32 each  MEM/WB data.
- write_reg_wb  out  5  MEM/WB destination register.
- timeout_err  out  1  registered one-cycle pulse.
- misalign_err  out  1  registered one-cycle pulse; tied to 0 when MISALIGN_TRAP_EN is undefined.

## Operation
- The state machine has two states: IDLE and WAIT.
- mem_op = MemRead | MemWrite. issue = IDLE & mem_op & ~misaligned.
- IDLE, no issue:
  - MEM/WB loads the inputs each edge. mem_data_wb keeps its previous value.
  - pc_src = Branch & Zero.
- IDLE, issue:
  - stall_out = 1.
  - At the edge, latch dmem_addr, dmem_wdata, dmem_we (= MemWrite), write_reg, MemToReg and RegWrite into the hold registers.
  - At the same edge, set dmem_req = 1, clear the timeout counter, and load a bubble into MEM/WB (RegWrite_wb = 0).
  - Go to WAIT.
- WAIT:
  - dmem_req stays 1 and the request fields stay stable. pc_src = 0.
  - stall_out = ~dmem_ack & ~expire, where expire = (cnt == TIMEOUT_CYCLES-1) & ~dmem_ack.
  - On dmem_ack:
    - Next edge: dmem_req = 0, mem_data_wb = dmem_rdata, and MEM/WB gets the held control/dest/alu_result.
    - A store writes back nothing, because its held RegWrite = 0.
    - Go to IDLE.
  - On expire:
    - Next edge: dmem_req = 0, timeout_err = 1 for one cycle, MEM/WB bubble.
    - Go to IDLE.
  - Otherwise the counter increments and a bubble is loaded into MEM/WB.
- dmem_ack while in IDLE is ignored.
- The counter width is $clog2(TIMEOUT_CYCLES+1), and the counter saturates, never wraps.

## Timing
- Reset:
  - State goes to IDLE.
  - All registered outputs go to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, all *_wb outputs, timeout_err and misalign_err.
  - The counter goes to 0.
  - Reset in WAIT drops dmem_req at that edge and discards the access.
- Non-memory instruction: 1 edge from EX/MEM output to the *_wb outputs.
- Load with ack in the first WAIT cycle:
  - The instruction is present for 2 cycles.
  - stall_out is high for 1 cycle (the issue cycle only).
  - The result reaches the *_wb outputs 2 edges after the instruction first appears.
- Each extra wait cycle adds 1 cycle of stall and 1 bubble.
- stall_out is low in the ack cycle, so EX/MEM advances at the same edge that completes the access.
- Back-to-back memory ops: the next issue occurs in the first IDLE cycle after completion.

## Configuration
- MISALIGN_TRAP_EN defined:
  - misaligned = mem_op & (alu_result[1:0] != 0).
  - A misaligned op causes no issue and no stall.
  - Next edge: misalign_err = 1 for one cycle, MEM/WB bubble, store suppressed.
- MISALIGN_TRAP_EN undefined:
  - misaligned = 0.
  - dmem_addr[1:0] is forced to 2'b00.
  - misalign_err = 0.

## Test plan
- R-type pass-through: alu_result = 0x1234, RegWrite = 1, write_reg = 5 -> after 1 edge, alu_result_wb = 0x1234, RegWrite_wb = 1, write_reg_wb = 5, and stall_out never high.
- Load with ack 3 cycles after req: alu_result = 0x40, dmem_rdata = 0xDEADBEEF -> stall_out is high 3 cycles, there are 3 bubbles, then mem_data_wb = 0xDEADBEEF, MemToReg_wb = 1, and dmem_req falls the same edge.
- Store with immediate ack: address 0x80, data 0xA5A5A5A5 -> dmem_we = 1 and dmem_addr = 0x80 for one req cycle, RegWrite_wb stays 0, and stall_out is high 1 cycle.
- Timeout: TIMEOUT_CYCLES = 4 and ack never arrives -> req is high 4 cycles, then timeout_err pulses once, RegWrite_wb = 0, and state returns to IDLE.
- Branch: Branch = 1, Zero = 1, target 0x100 -> pc_src = 1 and pc_target = 0x100 the same cycle. With Zero = 0, pc_src = 0.
- Reset asserted in WAIT, plus misaligned load at address 0x42:
  - Reset in WAIT -> dmem_req = 0 and all *_wb = 0 next edge.
  - Misaligned load at 0x42 with MISALIGN_TRAP_EN -> misalign_err pulse and no req. Without the macro -> dmem_addr = 0x40.
